// File: rtl/matrix_key_scan.sv
// 4x4 active-low keypad scanner: walks one column low at a time, collects a full
// 16-key snapshot per scan and debounces press/release over whole scans.
module matrix_key_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int             PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [7:0]     DB_N      = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB
  } state_t;

  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_sync;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_col_idx;
  logic [11:0]   r_acc;

  state_t        r_state;
  logic [3:0]    r_cand;
  logic [7:0]    r_cnt;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_key_down;

  logic          w_tick;
  logic          w_scan_done;
  logic [15:0]   w_scan;
  logic [15:0]   w_low;
  logic [4:0]    w_nlow;
  logic [3:0]    w_idx;
  logic          w_none;
  logic          w_single;
  logic [3:0]    w_code;

  state_t        w_state_nxt;
  logic [3:0]    w_cand_nxt;
  logic [7:0]    w_cnt_nxt;
  logic [7:0]    w_cnt_inc;
  logic [3:0]    w_code_nxt;
  logic          w_valid_nxt;
  logic          w_down_nxt;

  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_scan_done = w_tick && (r_col_idx == 2'd3);

  // Column 3 is taken straight from the synchroniser on the scan_done tick,
  // so the snapshot is complete in the same cycle it is evaluated.
  assign w_scan  = {r_row_sync, r_acc};
  assign col_out = ~(4'b0001 << r_col_idx);

  always_comb begin
    w_low  = ~w_scan;
    w_nlow = 5'd0;
    w_idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_low[i]) begin
        w_nlow = w_nlow + 5'd1;
        w_idx  = 4'(i);
      end
    end
  end

  // Snapshot index is col*4+row; the reported code is {row, col}.
  assign w_none   = (w_nlow == 5'd0);
  assign w_single = (w_nlow == 5'd1);
  assign w_code   = {w_idx[1:0], w_idx[3:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
      r_presc    <= '0;
      r_col_idx  <= 2'd0;
      r_acc      <= 12'hFFF;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
      r_presc    <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_col_idx <= r_col_idx + 2'd1;
        case (r_col_idx)
          2'd0:    r_acc[3:0]  <= r_row_sync;
          2'd1:    r_acc[7:4]  <= r_row_sync;
          2'd2:    r_acc[11:8] <= r_row_sync;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_down_nxt  = r_key_down;
    w_cnt_inc   = r_cnt + 8'd1;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_code;
            w_cnt_nxt  = 8'd1;
            if (DB_N == 8'd1) begin
              w_code_nxt  = w_code;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_HELD;
            end else begin
              w_state_nxt = S_PRESS_DB;
            end
          end
        end
        S_PRESS_DB: begin
          if (w_single && (w_code == r_cand)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DB_N) begin
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_HELD;
            end
          end else begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_IDLE;
          end
        end
        S_HELD: begin
          // Any key activity while held is ignored until a clean release.
          if (w_none) begin
            w_cnt_nxt = 8'd1;
            if (DB_N == 8'd1) begin
              w_down_nxt  = 1'b0;
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_REL_DB;
            end
          end
        end
        default: begin
          if (w_none) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DB_N) begin
              w_down_nxt  = 1'b0;
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'h0;
      r_cnt       <= 8'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_down  <= w_down_nxt;
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: a keypad model drives the rows from the column
// strobes; a scan-level debounce model predicts every output cycle by cycle.
module tb_matrix_key_scan;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int SCAN_LEN = 4 * SCAN_DIV;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  // Pressed keys, indexed by key code = row*4 + col.
  logic [15:0] keys;

  int          n_checks;
  int          n_fail;
  int          dut_pulses;

  logic        m_down;
  logic        m_pulse;
  logic [3:0]  m_code;
  logic [3:0]  m_cand;
  int          m_run;

  matrix_key_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_out[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[r * 4 + c]) row_in[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_down  = 1'b0;
    m_pulse = 1'b0;
    m_code  = 4'h0;
    m_cand  = 4'h0;
    m_run   = 0;
  endtask

  // One whole scan's worth of key state applied to the debounce rules.
  task automatic model_scan(input logic [15:0] mask);
    int         n;
    logic [3:0] code;
    n       = $countones(mask);
    code    = 4'h0;
    m_pulse = 1'b0;
    for (int k = 0; k < 16; k++) if (mask[k]) code = 4'(k);
    if (!m_down) begin
      if (n == 1) begin
        if (m_run == 0) begin
          m_cand = code;
          m_run  = 1;
        end else if (code == m_cand) begin
          m_run++;
        end else begin
          m_run = 0;
        end
        if (m_run == DB) begin
          m_down  = 1'b1;
          m_code  = m_cand;
          m_pulse = 1'b1;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_run++;
        if (m_run == DB) begin
          m_down = 1'b0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] mask);
    logic [3:0] exp_col;
    keys = mask;
    for (int i = 1; i <= SCAN_LEN; i++) begin
      @(posedge clk);
      if (i == SCAN_LEN) model_scan(mask);
      else m_pulse = 1'b0;
      #1;
      exp_col = 4'b0001 << ((i / SCAN_DIV) % 4);
      exp_col = ~exp_col;
      check("col_out", col_out, exp_col);
      check("key_valid", {3'b000, key_valid}, {3'b000, m_pulse});
      check("key_down", {3'b000, key_down}, {3'b000, m_down});
      check("key_code", key_code, m_code);
      if (key_valid) dut_pulses++;
    end
  endtask

  task automatic do_reset(input int pre);
    repeat (pre) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_valid", {3'b000, key_valid}, 4'h0);
    check("rst_key_down", {3'b000, key_down}, 4'h0);
    check("rst_key_code", key_code, 4'h0);
    @(posedge clk);
    #1;
    check("rst_hold_col_out", col_out, 4'b1110);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] mask;
    int          sel;
    int          hold;
    n_checks   = 0;
    n_fail     = 0;
    dut_pulses = 0;
    keys       = 16'h0000;
    rst        = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_col_out", col_out, 4'b1110);
    check("init_key_valid", {3'b000, key_valid}, 4'h0);
    check("init_key_down", {3'b000, key_down}, 4'h0);
    check("init_key_code", key_code, 4'h0);
    rst = 1'b0;

    // Idle scanning, then a reset in the middle of a scan
    repeat (2) run_scan(16'h0000);
    do_reset(6);
    run_scan(16'h0000);
    check("idle_pulses", 4'(dut_pulses), 4'd0);

    // Clean press and release of key 9
    dut_pulses = 0;
    repeat (5) run_scan(16'h0200);
    repeat (4) run_scan(16'h0000);
    check("press9_pulses", 4'(dut_pulses), 4'd1);
    check("press9_code", key_code, 4'h9);
    check("press9_down", {3'b000, key_down}, 4'h0);

    // Press bounce on key F
    dut_pulses = 0;
    repeat (2) run_scan(16'h8000);
    run_scan(16'h0000);
    repeat (3) run_scan(16'h8000);
    check("bounceF_pulses", 4'(dut_pulses), 4'd1);
    check("bounceF_code", key_code, 4'hF);
    repeat (3) run_scan(16'h0000);

    // Two keys together never report; roll-over while held is ignored
    dut_pulses = 0;
    repeat (6) run_scan(16'h0021);
    check("multi_pulses", 4'(dut_pulses), 4'd0);
    repeat (3) run_scan(16'h0008);
    repeat (2) run_scan(16'h0088);
    check("roll_down", {3'b000, key_down}, 4'h1);
    repeat (3) run_scan(16'h0000);
    check("roll_pulses", 4'(dut_pulses), 4'd1);
    check("roll_code", key_code, 4'h3);
    check("roll_released", {3'b000, key_down}, 4'h0);

    // Release bounce on key A
    dut_pulses = 0;
    repeat (3) run_scan(16'h0400);
    repeat (2) run_scan(16'h0000);
    run_scan(16'h0400);
    repeat (2) run_scan(16'h0000);
    check("relA_still_down", {3'b000, key_down}, 4'h1);
    run_scan(16'h0000);
    check("relA_pulses", 4'(dut_pulses), 4'd1);
    check("relA_released", {3'b000, key_down}, 4'h0);

    // Reset discards a debounce in progress on key 6
    dut_pulses = 0;
    repeat (2) run_scan(16'h0040);
    do_reset(5);
    repeat (2) run_scan(16'h0040);
    check("rst6_not_yet", 4'(dut_pulses), 4'd0);
    run_scan(16'h0040);
    check("rst6_pulses", 4'(dut_pulses), 4'd1);
    check("rst6_code", key_code, 4'h6);
    repeat (3) run_scan(16'h0000);

    // Random key activity: none, single or paired keys with random hold times
    for (int k = 0; k < 30; k++) begin
      sel  = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 4));
      mask = 16'h0000;
      if (sel == 1 || sel == 2) begin
        mask[$urandom_range(0, 15)] = 1'b1;
      end else if (sel == 3) begin
        mask[$urandom_range(0, 15)] = 1'b1;
        mask[$urandom_range(0, 15)] = 1'b1;
      end
      repeat (hold) run_scan(mask);
      if (k == 15) do_reset(int'($urandom_range(1, SCAN_LEN - 1)));
    end
    repeat (4) run_scan(16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
